// File: rtl/inout_sram_reader.sv
// ---------------------------------------------------------------------------
// inout_sram_reader
// Streaming read DMA for the input/output feature-map SRAM. Reads `length`
// consecutive words from `base_addr` and streams them out on valid/ready.
// The SRAM's 1-cycle read latency is absorbed by an `inflight` flag, and a
// 2-entry FIFO keeps one word per cycle under back-pressure.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   start, abort             request pulse (IDLE only) / synchronous flush
//   base_addr, length        transfer descriptor, sampled with start
//   busy, done, err          status: not idle / end pulse / sticky range error
//   mem_cs, mem_oe, mem_web  SRAM read strobes (web held high)
//   mem_addr, mem_rdata      SRAM word address / read data (1-cycle latency)
//   out_valid, out_ready     output stream handshake
//   out_data, out_last       stream payload and final-word marker
//
// Build option: INOUT_SRAM_READER_BOUND_CHECK_EN enables the range check of
// base_addr + length against MAX_WORDS; without it err is tied low and
// addresses simply wrap.
// ---------------------------------------------------------------------------
module inout_sram_reader #(
   parameter int unsigned AW        = 18,
   parameter int unsigned DW        = 16,
   parameter int unsigned MAX_WORDS = 196608
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          abort,
   input  logic [AW-1:0] base_addr,
   input  logic [AW-1:0] length,
   output logic          busy,
   output logic          done,
   output logic          err,
   output logic          mem_cs,
   output logic          mem_oe,
   output logic          mem_web,
   output logic [AW-1:0] mem_addr,
   input  logic [DW-1:0] mem_rdata,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_data,
   output logic          out_last
);

   localparam int unsigned CNT_W = 2;
   localparam int unsigned OCC_W = 3;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic [AW-1:0]      rd_addr_q, rd_addr_d;
   logic [AW-1:0]      issue_left_q, issue_left_d;
   logic [AW-1:0]      out_left_q, out_left_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic               inflight_q, inflight_d;
   logic               wr_ptr_q, wr_ptr_d;
   logic               rd_ptr_q, rd_ptr_d;
   logic               err_q, err_d;
   logic [DW-1:0]      fifo_q [2];

   logic [OCC_W-1:0]   occ_c;
   logic               pop_c;
   logic               issue_c;
   logic               accept_c;
   logic               range_err_c;

   // Range check on the requested window, evaluated one bit wider than AW.
`ifdef INOUT_SRAM_READER_BOUND_CHECK_EN
   assign range_err_c = ((AW+1)'(base_addr) + (AW+1)'(length)) > (AW+1)'(MAX_WORDS);
`else
   assign range_err_c = 1'b0;
`endif

   // Occupancy counts words buffered plus the one returning from the SRAM.
   assign occ_c    = OCC_W'(count_q) + OCC_W'(inflight_q);
   assign pop_c    = (count_q != '0) && out_ready;
   assign accept_c = (state_q == S_IDLE) && start && !abort;
   // A read may reuse the slot freed by a pop in the same cycle.
   assign issue_c  = (state_q == S_RUN) && !abort && (issue_left_q != '0) &&
                     ((occ_c < OCC_W'(2)) || ((occ_c == OCC_W'(2)) && pop_c));

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic; DRAIN looks ahead so done follows the last pop directly.
   always_comb begin
      state_d = state_q;
      if (abort) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE:  if (start) state_d = ((length == '0) || range_err_c) ? S_DONE : S_RUN;
            S_RUN:   if (issue_c && (issue_left_q == AW'(1))) state_d = S_DRAIN;
            S_DRAIN: if (!inflight_q && ((count_q == '0) ||
                         ((count_q == CNT_W'(1)) && pop_c))) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
         endcase
      end
   end

   // Output decode.
   always_comb begin
      busy      = (state_q != S_IDLE);
      done      = (state_q == S_DONE);
      err       = err_q;
      mem_cs    = issue_c;
      mem_oe    = inflight_q;
      mem_web   = 1'b1;
      mem_addr  = rd_addr_q;
      out_valid = (count_q != '0);
      out_data  = fifo_q[rd_ptr_q];
      out_last  = (out_left_q == AW'(1)) && (count_q != '0);
   end

   // Datapath next-state: counters, FIFO pointers and occupancy.
   always_comb begin
      rd_addr_d    = rd_addr_q;
      issue_left_d = issue_left_q;
      out_left_d   = out_left_q;
      count_d      = count_q;
      inflight_d   = inflight_q;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      err_d        = err_q;
      if (abort) begin
         rd_addr_d    = '0;
         issue_left_d = '0;
         out_left_d   = '0;
         count_d      = '0;
         inflight_d   = 1'b0;
         wr_ptr_d     = 1'b0;
         rd_ptr_d     = 1'b0;
      end else if (accept_c) begin
         rd_addr_d    = base_addr;
         issue_left_d = length;
         out_left_d   = length;
         err_d        = range_err_c;
      end else begin
         if (issue_c) begin
            rd_addr_d    = rd_addr_q + AW'(1);
            issue_left_d = issue_left_q - AW'(1);
         end
         if (pop_c) begin
            out_left_d = out_left_q - AW'(1);
            rd_ptr_d   = ~rd_ptr_q;
         end
         if (inflight_q) wr_ptr_d = ~wr_ptr_q;
         count_d    = count_q + CNT_W'(inflight_q) - CNT_W'(pop_c);
         inflight_d = issue_c;
      end
   end

   // Datapath registers; returning read data lands in the FIFO write slot.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_addr_q    <= '0;
         issue_left_q <= '0;
         out_left_q   <= '0;
         count_q      <= '0;
         inflight_q   <= 1'b0;
         wr_ptr_q     <= 1'b0;
         rd_ptr_q     <= 1'b0;
         err_q        <= 1'b0;
         fifo_q[0]    <= '0;
         fifo_q[1]    <= '0;
      end else begin
         rd_addr_q    <= rd_addr_d;
         issue_left_q <= issue_left_d;
         out_left_q   <= out_left_d;
         count_q      <= count_d;
         inflight_q   <= inflight_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         err_q        <= err_d;
         if (!abort && inflight_q) fifo_q[wr_ptr_q] <= mem_rdata;
      end
   end

endmodule

// File: tb/tb_inout_sram_reader.sv
// ---------------------------------------------------------------------------
// tb_inout_sram_reader
// Directed bench for inout_sram_reader with a behavioural 1-cycle-latency
// SRAM. Cycle k is the clock period following edge k-1 (start sampled at
// edge 0); outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_inout_sram_reader;

   localparam int unsigned AW   = 18;
   localparam int unsigned DW   = 16;
   localparam int unsigned MAXW = 196608;

   logic          clk = 1'b0;
   logic          rst, start, abort, out_ready;
   logic [AW-1:0] base_addr, length;
   logic          busy, done, err, mem_cs, mem_oe, mem_web;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_rdata = '0;
   logic          out_valid, out_last;
   logic [DW-1:0] out_data;

   always #5 clk = ~clk;

   inout_sram_reader dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .base_addr(base_addr), .length(length),
      .busy(busy), .done(done), .err(err),
      .mem_cs(mem_cs), .mem_oe(mem_oe), .mem_web(mem_web),
      .mem_addr(mem_addr), .mem_rdata(mem_rdata),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_last(out_last)
   );

   // SRAM model: populated below MAXW, reads 0 above it.
   logic [DW-1:0] sram [0:(1<<AW)-1];
   always @(posedge clk) begin
      if (mem_cs && mem_web)
         mem_rdata <= (32'(mem_addr) < MAXW) ? sram[mem_addr] : '0;
   end

   int checks = 0;
   int errors = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   logic [DW-1:0] got_w[$];
   int            got_c[$];
   int            last_n, last_at, done_cyc, first_cs, cs_cnt, hs_cnt;
   int            stall_viol, occ_viol;
   logic          busy_at [64];
   logic          valid_at[64];

   // One transfer; rmode 0 = ready held high, 1 = ready pattern 1,0,0 repeating.
   task automatic run_xfer(input logic [AW-1:0] b, input logic [AW-1:0] n, input int rmode,
                           input int restart_c, input int abort_c, input int budget);
      logic pv, pr, pl;
      logic [DW-1:0] pd;
      got_w.delete(); got_c.delete();
      last_n = 0; last_at = -1; done_cyc = -1; first_cs = -1;
      cs_cnt = 0; hs_cnt = 0; stall_viol = 0; occ_viol = 0;
      pv = 1'b0; pr = 1'b0; pl = 1'b0; pd = '0;
      for (int i = 0; i < 64; i++) begin busy_at[i] = 1'b0; valid_at[i] = 1'b0; end
      @(negedge clk);
      base_addr = b; length = n; start = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int c = 1; c <= budget; c++) begin
         out_ready = (rmode == 0) ? 1'b1 : ((c - 1) % 3 == 0);
         start = (c == restart_c);
         if (start) begin base_addr = 18'h300; length = 18'd2; end
         abort = (c == abort_c);
         @(negedge clk);
         if (c < 64) begin busy_at[c] = busy; valid_at[c] = out_valid; end
         if (mem_cs) begin
            cs_cnt++;
            if (first_cs < 0) first_cs = c;
         end
         if (pv && !pr && (!out_valid || out_data !== pd || out_last !== pl)) stall_viol++;
         if (out_last && !out_valid) stall_viol++;
         if (out_valid && out_ready) begin
            got_w.push_back(out_data);
            got_c.push_back(c);
            hs_cnt++;
            if (out_last) begin last_n++; last_at = got_w.size() - 1; end
         end
         if (cs_cnt - hs_cnt > 2) occ_viol++;
         if (done && done_cyc < 0) done_cyc = c;
         pv = out_valid; pr = out_ready; pd = out_data; pl = out_last;
         if (done_cyc >= 0) break;
         @(posedge clk); #1;
      end
      start = 1'b0; abort = 1'b0; out_ready = 1'b1;
   endtask

   function automatic logic [31:0] word_at(input int i);
      return (i < got_w.size()) ? 32'(got_w[i]) : 32'hDEAD_BEEF;
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b1;
      base_addr = '0; length = '0;
      for (int i = 0; i < (1 << AW); i++) sram[i] = '0;
      for (int i = 0; i < 16; i++) sram[18'h100 + i] = 16'hA000 + 16'(i);
      for (int i = 0; i < 4; i++)  sram[18'h200 + i] = 16'hC000 + 16'(i);
      for (int i = 0; i < 4; i++)  sram[18'h7FFE + i] = 16'hB000 + 16'(i);
      sram[18'h2FFFE] = 16'hD000;
      sram[18'h2FFFF] = 16'hD001;

      // Reset values
      #12;
      check_eq("rst_busy", 32'(busy), 0);
      check_eq("rst_done", 32'(done), 0);
      check_eq("rst_err", 32'(err), 0);
      check_eq("rst_cs", 32'(mem_cs), 0);
      check_eq("rst_oe", 32'(mem_oe), 0);
      check_eq("rst_web", 32'(mem_web), 1);
      check_eq("rst_addr", 32'(mem_addr), 0);
      check_eq("rst_valid", 32'(out_valid), 0);
      check_eq("rst_data", 32'(out_data), 0);
      check_eq("rst_last", 32'(out_last), 0);
      @(negedge clk); rst = 1'b0;

      // Basic read, ready held high
      run_xfer(18'h100, 18'd8, 0, 0, 0, 40);
      check_eq("basic_n", 32'(got_w.size()), 8);
      for (int i = 0; i < 8; i++) check_eq("basic_word", word_at(i), 32'(16'hA000 + 16'(i)));
      check_eq("basic_first_cyc", (got_c.size() > 0) ? 32'(got_c[0]) : 32'hFFFF, 3);
      check_eq("basic_last_cyc", (got_c.size() > 7) ? 32'(got_c[7]) : 32'hFFFF, 10);
      check_eq("basic_last_n", 32'(last_n), 1);
      check_eq("basic_last_at", 32'(last_at), 7);
      check_eq("basic_first_cs", 32'(first_cs), 1);
      check_eq("basic_cs_cnt", 32'(cs_cnt), 8);
      check_eq("basic_done_cyc", 32'(done_cyc), 11);

      // Back-pressure
      run_xfer(18'h100, 18'd8, 1, 0, 0, 60);
      check_eq("bp_n", 32'(got_w.size()), 8);
      for (int i = 0; i < 8; i++) check_eq("bp_word", word_at(i), 32'(16'hA000 + 16'(i)));
      check_eq("bp_stall", 32'(stall_viol), 0);
      check_eq("bp_occ", 32'(occ_viol), 0);
      check_eq("bp_last_at", 32'(last_at), 7);
      check_eq("bp_done_seen", 32'(done_cyc > 0), 1);

      // Zero length
      run_xfer(18'h40, 18'd0, 0, 0, 0, 10);
      check_eq("zero_done_cyc", 32'(done_cyc), 1);
      check_eq("zero_cs_cnt", 32'(cs_cnt), 0);
      check_eq("zero_n", 32'(got_w.size()), 0);

      // Second start during RUN is ignored
      run_xfer(18'h100, 18'd8, 0, 4, 0, 40);
      check_eq("ign_n", 32'(got_w.size()), 8);
      for (int i = 0; i < 8; i++) check_eq("ign_word", word_at(i), 32'(16'hA000 + 16'(i)));
      check_eq("ign_cs_cnt", 32'(cs_cnt), 8);
      check_eq("ign_done_cyc", 32'(done_cyc), 11);
      repeat (3) @(negedge clk);
      check_eq("ign_idle", 32'(busy), 0);

      // Abort on the 4th word (cycle 6) of a 16-word transfer
      run_xfer(18'h100, 18'd16, 0, 0, 6, 20);
      check_eq("abt_word3", word_at(3), 32'hA003);
      check_eq("abt_busy_before", 32'(busy_at[6]), 1);
      check_eq("abt_busy_after", 32'(busy_at[7]), 0);
      check_eq("abt_valid_after", 32'(valid_at[7]), 0);
      check_eq("abt_no_done", done_cyc, -1);
      run_xfer(18'h200, 18'd4, 0, 0, 0, 30);
      check_eq("post_abt_n", 32'(got_w.size()), 4);
      for (int i = 0; i < 4; i++) check_eq("post_abt_word", word_at(i), 32'(16'hC000 + 16'(i)));
      check_eq("post_abt_done_cyc", 32'(done_cyc), 7);

      // Bank 0 -> bank 1 crossing
      run_xfer(18'h7FFE, 18'd4, 0, 0, 0, 30);
      check_eq("bank_n", 32'(got_w.size()), 4);
      for (int i = 0; i < 4; i++) check_eq("bank_word", word_at(i), 32'(16'hB000 + 16'(i)));
      check_eq("bank_done_cyc", 32'(done_cyc), 7);

      // Window running past the last populated bank
      run_xfer(18'h2FFFE, 18'd4, 0, 0, 0, 30);
`ifdef INOUT_SRAM_READER_BOUND_CHECK_EN
      check_eq("bound_err", 32'(err), 1);
      check_eq("bound_cs_cnt", 32'(cs_cnt), 0);
      check_eq("bound_n", 32'(got_w.size()), 0);
      check_eq("bound_done_cyc", 32'(done_cyc), 1);
`else
      check_eq("bound_err", 32'(err), 0);
      check_eq("bound_n", 32'(got_w.size()), 4);
      check_eq("bound_w0", word_at(0), 32'hD000);
      check_eq("bound_w1", word_at(1), 32'hD001);
      check_eq("bound_w2", word_at(2), 32'h0);
      check_eq("bound_w3", word_at(3), 32'h0);
      check_eq("bound_done_cyc", 32'(done_cyc), 7);
`endif

      // Asynchronous reset mid-RUN (cycle 4, between clock edges)
      @(negedge clk);
      base_addr = 18'h100; length = 18'd8; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      check_eq("arst_pre_busy", 32'(busy), 1);
      check_eq("arst_pre_valid", 32'(out_valid), 1);
      rst = 1'b1;
      #1;
      check_eq("arst_busy", 32'(busy), 0);
      check_eq("arst_valid", 32'(out_valid), 0);
      check_eq("arst_cs", 32'(mem_cs), 0);
      check_eq("arst_oe", 32'(mem_oe), 0);
      check_eq("arst_addr", 32'(mem_addr), 0);
      check_eq("arst_data", 32'(out_data), 0);
      check_eq("arst_last", 32'(out_last), 0);
      check_eq("arst_done", 32'(done), 0);
      check_eq("arst_web", 32'(mem_web), 1);
      @(negedge clk); rst = 1'b0;
      @(negedge clk);
      check_eq("arst_stays_idle", 32'(busy), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
